spi_master_9952: RTL and testbench

SPI_MASTER_9952 -- requirements
Module: spi_master_9952

---
 rtl/spi_9952_pkg.sv | 14 +
 rtl/spi_master_9952.sv | 145 ++++++++++++++
 tb/tb_spi_master_9952.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_9952_pkg.sv
// rtl/spi_9952_pkg.sv - shared constants and state encoding for the AD9952 SPI master
package spi_9952_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/spi_master_9952.sv
// rtl/spi_master_9952.sv - byte-stream SPI master for the AD9952, SCLK = clk/2, MSB first
module spi_master_9952
    import spi_9952_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              have_data,
    input  logic [BYTE_W-1:0] data_i,
    output logic              rdreq,
    output logic              mosi,
    output logic              sclk,
    output logic              cs_n,
    output logic              io_update,
    input  logic              miso,
    output logic [BYTE_W-1:0] miso_reg,
    output logic              wrreq,
    output logic              high_z,
    output logic              my_ena,
    output logic              my_state,
    output logic [CNT_W-1:0]  my_cnt_bit,
    output logic [BYTE_W-1:0] my_mosi_reg,
    output logic              my_load_cond
);

    state_t             state_q, state_d;
    logic               ena_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  mosi_reg_q, mosi_reg_d;
    logic [BYTE_W-1:0]  rx_q, rx_d;
    logic [BYTE_W-1:0]  miso_reg_q, miso_reg_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               high_z_q, high_z_d;
    logic               rdreq_q, rdreq_d;
    logic               wrreq_q, wrreq_d;
    logic               io_q, io_d;

    logic               load_cond;
    logic               byte_end;
    logic [CNT_W-1:0]   next_idx;

    // Loads happen either from idle or exactly at the last bit, so bursts chain without a cs_n gap.
    assign load_cond = ena_q && have_data && ((state_q == ST_IDLE) || (cnt_q == LAST_BIT));
    assign byte_end  = (state_q == ST_XFER) && ena_q && (cnt_q == LAST_BIT);
    assign next_idx  = LAST_BIT - cnt_q - CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ena_q      <= 1'b0;
            cnt_q      <= '0;
            mosi_reg_q <= '0;
            rx_q       <= '0;
            miso_reg_q <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            high_z_q   <= 1'b1;
            rdreq_q    <= 1'b0;
            wrreq_q    <= 1'b0;
            io_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ena_q      <= ~ena_q;
            cnt_q      <= cnt_d;
            mosi_reg_q <= mosi_reg_d;
            rx_q       <= rx_d;
            miso_reg_q <= miso_reg_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            high_z_q   <= high_z_d;
            rdreq_q    <= rdreq_d;
            wrreq_q    <= wrreq_d;
            io_q       <= io_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mosi_reg_d = mosi_reg_q;
        rx_d       = rx_q;
        miso_reg_d = miso_reg_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        high_z_d   = high_z_q;
        rdreq_d    = 1'b0;
        wrreq_d    = 1'b0;
        io_d       = 1'b0;

        // miso is sampled on the falling sclk edge, half a bit after the slave launched it.
        if ((state_q == ST_XFER) && ena_q) begin
            rx_d = {rx_q[BYTE_W-2:0], miso};
        end

        if (byte_end) begin
            miso_reg_d = {rx_q[BYTE_W-2:0], miso};
            wrreq_d    = 1'b1;
        end

        if (load_cond) begin
            rdreq_d    = 1'b1;
            mosi_reg_d = data_i;
            mosi_d     = data_i[BYTE_W-1];
            cnt_d      = '0;
            cs_n_d     = 1'b0;
            high_z_d   = 1'b0;
            sclk_d     = 1'b0;
            state_d    = ST_XFER;
        end else if (state_q == ST_XFER) begin
            if (!ena_q) begin
                sclk_d = 1'b1;
            end else if (cnt_q == LAST_BIT) begin
                state_d  = ST_IDLE;
                cs_n_d   = 1'b1;
                high_z_d = 1'b1;
                sclk_d   = 1'b0;
                mosi_d   = 1'b0;
                io_d     = 1'b1;
            end else begin
                sclk_d = 1'b0;
                cnt_d  = cnt_q + CNT_W'(1);
                mosi_d = mosi_reg_q[next_idx];
            end
        end
    end

    assign rdreq        = rdreq_q;
    assign mosi         = mosi_q;
    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign io_update    = io_q;
    assign miso_reg     = miso_reg_q;
    assign wrreq        = wrreq_q;
    assign high_z       = high_z_q;
    assign my_ena       = ena_q;
    assign my_state     = state_q;
    assign my_cnt_bit   = cnt_q;
    assign my_mosi_reg  = mosi_reg_q;
    assign my_load_cond = load_cond;

endmodule

// File: tb/tb_spi_master_9952.sv
// tb/tb_spi_master_9952.sv - self-checking bench for spi_master_9952
module tb_spi_master_9952;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       have_data = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       miso = 1'b0;
    logic       rdreq, mosi, sclk, cs_n, io_update, wrreq, high_z;
    logic [7:0] miso_reg;
    logic       my_ena, my_state, my_load_cond;
    logic [2:0] my_cnt_bit;
    logic [7:0] my_mosi_reg;

    int checks = 0;
    int errors = 0;

    spi_master_9952 dut (
        .clk(clk), .rst(rst), .have_data(have_data), .data_i(data_i),
        .rdreq(rdreq), .mosi(mosi), .sclk(sclk), .cs_n(cs_n),
        .io_update(io_update), .miso(miso), .miso_reg(miso_reg),
        .wrreq(wrreq), .high_z(high_z), .my_ena(my_ena), .my_state(my_state),
        .my_cnt_bit(my_cnt_bit), .my_mosi_reg(my_mosi_reg),
        .my_load_cond(my_load_cond)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: tasks write entries, this process consumes on rdreq.
    logic [7:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit hold = 1'b0;

    always @(negedge clk) begin
        if (rdreq) rd_ptr = rd_ptr + 1;
        have_data = (wr_ptr != rd_ptr) && !hold;
        data_i    = fifo_mem[rd_ptr];
    end

    // Bus observer: logs mosi at each sclk rise, received bytes, pulses and cs_n low runs.
    bit         mosi_log [0:4095];
    int         mosi_n = 0;
    logic [7:0] rx_log [0:255];
    int         wr_n = 0;
    int         io_n = 0;
    int         io_wr_n = 0;
    int         long_n = 0;
    int         run = 0;
    int         cs_log [0:255];
    int         cs_runs = 0;
    bit prev_sclk = 0, prev_rd = 0, prev_wr = 0, prev_io = 0;

    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            mosi_log[mosi_n] = mosi;
            mosi_n = mosi_n + 1;
        end
        if (wrreq) begin
            rx_log[wr_n] = miso_reg;
            wr_n = wr_n + 1;
        end
        if (io_update) begin
            io_n = io_n + 1;
            if (wrreq) io_wr_n = io_wr_n + 1;
        end
        if ((rdreq && prev_rd) || (wrreq && prev_wr) || (io_update && prev_io)) long_n = long_n + 1;
        if (!cs_n) run = run + 1;
        else if (run != 0) begin
            cs_log[cs_runs] = run;
            cs_runs = cs_runs + 1;
            run = 0;
        end
        prev_sclk = sclk; prev_rd = rdreq; prev_wr = wrreq; prev_io = io_update;
    end

    // Slave model: launches a random bit 5 ns after every sclk rise.
    bit miso_log [0:4095];
    int miso_n = 0;

    always @(posedge sclk) begin
        #5;
        miso = 1'($urandom);
        miso_log[miso_n] = miso;
        miso_n = miso_n + 1;
    end

    task automatic wait_io(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (io_n > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bit4(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (my_state === 1'b1 && my_cnt_bit === 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic e0;
        int b_rd, b_wr, b_io, b_cs;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, high_z, rdreq, wrreq, io_update, my_ena, my_state} !== 9'b1_0_0_1_0_0_0_0_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {cs_n, sclk, mosi, high_z, rdreq, wrreq, io_update, my_ena, my_state}, 9'b100100000);
        end
        checks++;
        if (miso_reg !== 8'h00 || my_mosi_reg !== 8'h00 || my_cnt_bit !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h/%0d expected 00/00/0", miso_reg, my_mosi_reg, my_cnt_bit);
        end
        rst = 1'b1;
        b_rd = rd_ptr; b_wr = wr_n; b_io = io_n; b_cs = cs_runs;
        repeat (100) @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || high_z !== 1'b1) begin
            errors++;
            $display("FAIL idle_bus: got cs_n=%b sclk=%b high_z=%b expected 1 0 1", cs_n, sclk, high_z);
        end
        checks++;
        if ((rd_ptr - b_rd) + (wr_n - b_wr) + (io_n - b_io) + (cs_runs - b_cs) != 0) begin
            errors++;
            $display("FAIL idle_pulses: got rd=%0d wr=%0d io=%0d cs=%0d expected all 0",
                     rd_ptr - b_rd, wr_n - b_wr, io_n - b_io, cs_runs - b_cs);
        end
        e0 = my_ena;
        @(negedge clk);
        checks++;
        if (my_ena !== ~e0) begin
            errors++;
            $display("FAIL ena_toggle: got %b expected %b", my_ena, ~e0);
        end
    endtask

    // mode 0: alternating 0x55/0xAA starting at 0x55; mode 1: random bytes.
    task automatic test_burst(input string name, input int n, input bit mode);
        logic [7:0] exp_b [$];
        logic [7:0] b, got, exp_rx;
        bit ok;
        int b_rd, b_mosi, b_miso, b_wr, b_io, b_iow, b_long, b_cs;
        repeat (4) @(negedge clk);
        b_rd = rd_ptr; b_mosi = mosi_n; b_miso = miso_n; b_wr = wr_n;
        b_io = io_n; b_iow = io_wr_n; b_long = long_n; b_cs = cs_runs;
        for (int i = 0; i < n; i++) begin
            b = mode ? 8'($urandom) : ((i % 2 == 0) ? 8'h55 : 8'hAA);
            fifo_mem[wr_ptr] = b;
            wr_ptr = wr_ptr + 1;
            exp_b.push_back(b);
        end
        wait_io(b_io, 16 * n + 64, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no io_update expected one within %0d clk", name, 16 * n + 64);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_ptr - b_rd != n || wr_n - b_wr != n) begin
            errors++;
            $display("FAIL %s_counts: got rd=%0d wr=%0d expected %0d", name, rd_ptr - b_rd, wr_n - b_wr, n);
        end
        checks++;
        if (io_n - b_io != 1 || io_wr_n - b_iow != 1) begin
            errors++;
            $display("FAIL %s_io_update: got io=%0d io_with_wr=%0d expected 1 1", name, io_n - b_io, io_wr_n - b_iow);
        end
        checks++;
        if (cs_runs - b_cs != 1 || cs_log[b_cs] != 16 * n) begin
            errors++;
            $display("FAIL %s_cs_window: got runs=%0d len=%0d expected 1 %0d", name, cs_runs - b_cs, cs_log[b_cs], 16 * n);
        end
        checks++;
        if (mosi_n - b_mosi != 8 * n || long_n != b_long) begin
            errors++;
            $display("FAIL %s_edges: got sclk_rises=%0d long_pulses=%0d expected %0d 0", name, mosi_n - b_mosi, long_n - b_long, 8 * n);
        end
        for (int k = 0; k < n; k++) begin
            got = '0;
            exp_rx = '0;
            for (int j = 0; j < 8; j++) begin
                got    = {got[6:0], mosi_log[b_mosi + 8 * k + j]};
                exp_rx = {exp_rx[6:0], miso_log[b_miso + 8 * k + j]};
            end
            checks++;
            if (got !== exp_b[k]) begin
                errors++;
                $display("FAIL %s_mosi_byte%0d: got %h expected %h", name, k, got, exp_b[k]);
            end
            checks++;
            if (rx_log[b_wr + k] !== exp_rx) begin
                errors++;
                $display("FAIL %s_miso_byte%0d: got %h expected %h", name, k, rx_log[b_wr + k], exp_rx);
            end
        end
        checks++;
        if (cs_n !== 1'b1 || high_z !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
            errors++;
            $display("FAIL %s_end_idle: got cs_n=%b high_z=%b sclk=%b mosi=%b expected 1 1 0 0", name, cs_n, high_z, sclk, mosi);
        end
    endtask

    task automatic test_drop_mid_byte;
        logic [7:0] b0, b1, got;
        bit ok;
        int b_rd, b_mosi, b_io, b_wr, b_cs;
        repeat (4) @(negedge clk);
        b_rd = rd_ptr; b_mosi = mosi_n; b_io = io_n; b_wr = wr_n; b_cs = cs_runs;
        b0 = 8'($urandom); b1 = 8'($urandom);
        fifo_mem[wr_ptr] = b0; fifo_mem[wr_ptr + 1] = b1;
        wr_ptr = wr_ptr + 2;
        wait_bit4(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_reach_bit4: got timeout expected my_cnt_bit=4");
        end
        hold = 1'b1;
        wait_io(b_io, 100, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || io_n - b_io != 1 || rd_ptr - b_rd != 1 || wr_n - b_wr != 1) begin
            errors++;
            $display("FAIL drop_single_byte: got io=%0d rd=%0d wr=%0d expected 1 1 1", io_n - b_io, rd_ptr - b_rd, wr_n - b_wr);
        end
        checks++;
        if (cs_n !== 1'b1 || cs_runs - b_cs != 1 || cs_log[b_cs] != 16) begin
            errors++;
            $display("FAIL drop_cs: got cs_n=%b runs=%0d len=%0d expected 1 1 16", cs_n, cs_runs - b_cs, cs_log[b_cs]);
        end
        got = '0;
        for (int j = 0; j < 8; j++) got = {got[6:0], mosi_log[b_mosi + j]};
        checks++;
        if (got !== b0) begin
            errors++;
            $display("FAIL drop_mosi_byte0: got %h expected %h", got, b0);
        end
        hold = 1'b0;
        wait_io(b_io + 1, 100, ok);
        repeat (4) @(negedge clk);
        got = '0;
        for (int j = 0; j < 8; j++) got = {got[6:0], mosi_log[b_mosi + 8 + j]};
        checks++;
        if (!ok || io_n - b_io != 2 || rd_ptr - b_rd != 2 || got !== b1) begin
            errors++;
            $display("FAIL drop_resume: got io=%0d rd=%0d byte=%h expected 2 2 %h", io_n - b_io, rd_ptr - b_rd, got, b1);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int b_io, b_wr;
        repeat (4) @(negedge clk);
        b_io = io_n; b_wr = wr_n;
        fifo_mem[wr_ptr] = 8'($urandom);
        wr_ptr = wr_ptr + 1;
        wait_bit4(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach_bit4: got timeout expected my_cnt_bit=4");
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cs_n, sclk, mosi, high_z, rdreq, wrreq, io_update, my_ena, my_state} !== 9'b1_0_0_1_0_0_0_0_0) begin
            errors++;
            $display("FAIL abort_async_outputs: got %b expected %b",
                     {cs_n, sclk, mosi, high_z, rdreq, wrreq, io_update, my_ena, my_state}, 9'b100100000);
        end
        checks++;
        if (miso_reg !== 8'h00 || my_mosi_reg !== 8'h00 || my_cnt_bit !== 3'd0) begin
            errors++;
            $display("FAIL abort_async_regs: got %h/%h/%0d expected 00/00/0", miso_reg, my_mosi_reg, my_cnt_bit);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (io_n != b_io || wr_n != b_wr || cs_n !== 1'b1 || my_state !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_io_update: got io=%0d wr=%0d cs_n=%b state=%b expected 0 0 1 0",
                     io_n - b_io, wr_n - b_wr, cs_n, my_state);
        end
    endtask

    initial begin
        test_reset;
        test_burst("single55", 1, 1'b0);
        test_burst("single_rand", 1, 1'b1);
        test_burst("stream_alt", 31, 1'b0);
        test_burst("stream_rand", 12, 1'b1);
        test_drop_mid_byte;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
